// File: rtl/alarm_light_ctrl.sv
// alarm_light_ctrl
//   Multi-channel alarm controller for the digital clock. Each channel arms on
//   the rising edge of its time-match compare, rings until it is stopped, snoozed
//   or times out, and re-rings when a snooze runs out. Time is counted in ticks
//   of the 1 Hz enable pulse.
//
//   Ports
//     clk, reset_n  : system clock, asynchronous active-low reset
//     tick          : 1-cycle enable pulse at 1 Hz
//     eq            : per-channel time-match compare (level)
//     alarm_en      : per-channel arm; 0 holds the channel idle
//     stop_alarm    : per-channel stop request (level)
//     snooze        : per-channel snooze request (level)
//     alarm_clear   : synchronous clear of all channels and timeout flags
//     alarm_light   : channel is ringing
//     snoozing      : channel is snoozing
//     timed_out     : sticky, channel auto-stopped after ringing too long
//     alarm_any     : OR of alarm_light
//     blink         : toggles on each tick while any channel rings, else 0
//
//   Interface semantics: there is no valid/ready handshake. All request inputs
//   are levels sampled on every rising clk edge; tick qualifies time-based
//   updates only. The per-channel state is directly visible on alarm_light
//   (RINGING) and snoozing (SNOOZE); both low means IDLE.
module alarm_light_ctrl #(
    parameter int N_ALARMS      = 4,
    parameter int TIMEOUT_TICKS = 60,
    parameter int SNOOZE_TICKS  = 300,
    parameter int MAX_SNOOZE    = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic [N_ALARMS-1:0] eq,
    input  logic [N_ALARMS-1:0] alarm_en,
    input  logic [N_ALARMS-1:0] stop_alarm,
    input  logic [N_ALARMS-1:0] snooze,
    input  logic                alarm_clear,
    output logic [N_ALARMS-1:0] alarm_light,
    output logic [N_ALARMS-1:0] snoozing,
    output logic [N_ALARMS-1:0] timed_out,
    output logic                alarm_any,
    output logic                blink
);

    localparam int CNT_MAX = (TIMEOUT_TICKS > SNOOZE_TICKS) ? TIMEOUT_TICKS : SNOOZE_TICKS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    // Keep the snooze counter at least one bit wide even when snoozing is disabled.
    localparam int SW      = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    localparam logic [CW-1:0] CNT_TIMEOUT_LAST = CW'(TIMEOUT_TICKS - 1);
    localparam logic [CW-1:0] CNT_SNOOZE_LOAD  = CW'(SNOOZE_TICKS);
    localparam logic [CW-1:0] CNT_ONE          = CW'(1);
    localparam logic [SW-1:0] SNZ_LIMIT        = SW'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    state_t              state_q [N_ALARMS];
    state_t              state_d [N_ALARMS];
    logic [CW-1:0]       cnt_q   [N_ALARMS];
    logic [CW-1:0]       cnt_d   [N_ALARMS];
    logic [SW-1:0]       snz_q   [N_ALARMS];
    logic [SW-1:0]       snz_d   [N_ALARMS];
    logic [N_ALARMS-1:0] to_q;
    logic [N_ALARMS-1:0] to_d;
    logic [N_ALARMS-1:0] eq_d;
    logic [N_ALARMS-1:0] rise;
    logic                blink_q;

    // A held-high compare never retriggers: only a 0->1 change arms a channel.
    assign rise = eq & ~eq_d;

    // Next-state logic, one independent FSM per channel.
    always_comb begin
        for (int i = 0; i < N_ALARMS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            snz_d[i]   = snz_q[i];
            to_d[i]    = to_q[i];

            if (alarm_clear || !alarm_en[i]) begin
                state_d[i] = ST_IDLE;
                if (alarm_clear) begin
                    to_d[i] = 1'b0;
                end
            end else if (stop_alarm[i]) begin
                state_d[i] = ST_IDLE;
                to_d[i]    = 1'b0;
            end else begin
                unique case (state_q[i])
                    ST_IDLE: begin
                        // The entering edge does not count a coincident tick.
                        if (rise[i]) begin
                            state_d[i] = ST_RINGING;
                            cnt_d[i]   = '0;
                            snz_d[i]   = '0;
                            to_d[i]    = 1'b0;
                        end
                    end
                    ST_RINGING: begin
                        if (snooze[i] && (snz_q[i] < SNZ_LIMIT)) begin
                            state_d[i] = ST_SNOOZE;
                            cnt_d[i]   = CNT_SNOOZE_LOAD;
                            snz_d[i]   = snz_q[i] + 1'b1;
                        end else if (tick) begin
                            if (cnt_q[i] == CNT_TIMEOUT_LAST) begin
                                state_d[i] = ST_IDLE;
                                to_d[i]    = 1'b1;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 1'b1;
                            end
                        end
                    end
                    ST_SNOOZE: begin
                        if (tick) begin
                            if (cnt_q[i] == CNT_ONE) begin
                                state_d[i] = ST_RINGING;
                                cnt_d[i]   = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] - 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                snz_q[i]   <= '0;
            end
            to_q    <= '0;
            eq_d    <= '0;
            blink_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_ALARMS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                snz_q[i]   <= snz_d[i];
            end
            to_q <= to_d;
            eq_d <= eq;
            if (!alarm_any) begin
                blink_q <= 1'b0;
            end else if (tick) begin
                blink_q <= ~blink_q;
            end
        end
    end

    // Outputs are pure decodes of the state register.
    always_comb begin
        for (int i = 0; i < N_ALARMS; i++) begin
            alarm_light[i] = (state_q[i] == ST_RINGING);
            snoozing[i]    = (state_q[i] == ST_SNOOZE);
        end
    end

    assign timed_out = to_q;
    assign alarm_any = |alarm_light;
    // Masking with alarm_any forces blink low in the very cycle ringing stops.
    assign blink     = blink_q & alarm_any;

endmodule

// File: tb/tb_alarm_light_ctrl.sv
// tb_alarm_light_ctrl
//   Bench for alarm_light_ctrl with N_ALARMS=2, TIMEOUT_TICKS=5, SNOOZE_TICKS=3,
//   MAX_SNOOZE=2. Stimulus is applied on the falling edge; a behavioural model
//   predicts the outputs after the next rising edge and queues them; a monitor
//   compares the DUT outputs 1 ns after each rising edge.
module tb_alarm_light_ctrl;

    localparam int N       = 2;
    localparam int TIMEOUT = 5;
    localparam int SNZ     = 3;
    localparam int MAXS    = 2;
    localparam int W       = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic         tick = 1'b0;
    logic [N-1:0] eq = '0;
    logic [N-1:0] alarm_en = '0;
    logic [N-1:0] stop_alarm = '0;
    logic [N-1:0] snooze = '0;
    logic         alarm_clear = 1'b0;
    logic [N-1:0] alarm_light;
    logic [N-1:0] snoozing;
    logic [N-1:0] timed_out;
    logic         alarm_any;
    logic         blink;

    alarm_light_ctrl #(
        .N_ALARMS     (N),
        .TIMEOUT_TICKS(TIMEOUT),
        .SNOOZE_TICKS (SNZ),
        .MAX_SNOOZE   (MAXS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .eq         (eq),
        .alarm_en   (alarm_en),
        .stop_alarm (stop_alarm),
        .snooze     (snooze),
        .alarm_clear(alarm_clear),
        .alarm_light(alarm_light),
        .snoozing   (snoozing),
        .timed_out  (timed_out),
        .alarm_any  (alarm_any),
        .blink      (blink)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    function automatic logic [W-1:0] dut_outputs();
        return {blink, alarm_any, timed_out, snoozing, alarm_light};
    endfunction

    // ---------------- reference model ----------------
    // Per channel: ringing flag, ticks rung since (re)start, snooze ticks left
    // (nonzero means snoozing), snoozes taken this event, timeout flag.
    bit m_ring     [N];
    int m_elapsed  [N];
    int m_snz_left [N];
    int m_used     [N];
    bit m_to       [N];
    bit m_prev_eq  [N];
    bit m_blink;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_ring[c] = 0; m_elapsed[c] = 0; m_snz_left[c] = 0;
            m_used[c] = 0; m_to[c] = 0; m_prev_eq[c] = 0;
        end
        m_blink = 0;
    endtask

    function automatic logic [W-1:0] model_outputs();
        logic [N-1:0] light;
        logic [N-1:0] snz;
        logic [N-1:0] to;
        logic any;
        for (int c = 0; c < N; c++) begin
            light[c] = m_ring[c];
            snz[c]   = (m_snz_left[c] > 0);
            to[c]    = m_to[c];
        end
        any = |light;
        return {m_blink & any, any, to, snz, light};
    endfunction

    task automatic model_step();
        bit any_pre;
        bit rise;
        any_pre = m_ring[0] | m_ring[1];
        for (int c = 0; c < N; c++) begin
            rise = (eq[c] == 1'b1) && !m_prev_eq[c];
            if (alarm_clear || !alarm_en[c]) begin
                m_ring[c] = 0;
                m_snz_left[c] = 0;
                if (alarm_clear) m_to[c] = 0;
            end else if (stop_alarm[c]) begin
                m_ring[c] = 0;
                m_snz_left[c] = 0;
                m_to[c] = 0;
            end else if (m_ring[c]) begin
                if (snooze[c] && m_used[c] < MAXS) begin
                    m_ring[c] = 0;
                    m_snz_left[c] = SNZ;
                    m_used[c]++;
                end else if (tick) begin
                    m_elapsed[c]++;
                    if (m_elapsed[c] == TIMEOUT) begin
                        m_ring[c] = 0;
                        m_to[c] = 1;
                    end
                end
            end else if (m_snz_left[c] > 0) begin
                if (tick) begin
                    m_snz_left[c]--;
                    if (m_snz_left[c] == 0) begin
                        m_ring[c] = 1;
                        m_elapsed[c] = 0;
                    end
                end
            end else if (rise) begin
                m_ring[c] = 1;
                m_elapsed[c] = 0;
                m_used[c] = 0;
                m_to[c] = 0;
            end
            m_prev_eq[c] = (eq[c] == 1'b1);
        end
        if (!any_pre) m_blink = 0;
        else if (tick) m_blink = !m_blink;
        exp_q.push_back(model_outputs());
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick_step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick_step();
            step();
        end
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any clock edge.
    task automatic async_reset();
        logic [W-1:0] got;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        got = dut_outputs();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", got, {W{1'b0}});
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [W-1:0] exp;
        logic [W-1:0] got;
        forever begin
            @(posedge clk);
            cycle++;
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = dut_outputs();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got %b expected %b (blink,any,to[1:0],snz[1:0],light[1:0])",
                             cycle, got, exp);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        logic [W-1:0] got;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = dut_outputs();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", got, {W{1'b0}});
        end
        reset_n = 1'b1;
        alarm_en = 2'b11;

        // Rise rings on the same edge; one-cycle stop; held eq does not retrigger.
        eq = 2'b01; step();
        stop_alarm = 2'b01; step();
        stop_alarm = 2'b00; step(); step();
        eq = 2'b00; step();

        // Auto-timeout after 5 ticks; timed_out sticks until a stop.
        eq = 2'b01; step();
        eq = 2'b00; step();
        ticks(5);
        step(); step();
        stop_alarm = 2'b01; step();
        stop_alarm = 2'b00; step();

        // Timeout flag also clears on the next rise.
        eq = 2'b01; step(); eq = 2'b00; ticks(5);
        eq = 2'b01; step(); eq = 2'b00; step();
        stop_alarm = 2'b01; step(); stop_alarm = 2'b00; step();

        // Snooze twice, third snooze ignored.
        eq = 2'b01; step();
        eq = 2'b00; step();
        snooze = 2'b01; step(); snooze = 2'b00; ticks(3);
        snooze = 2'b01; step(); snooze = 2'b00; ticks(3);
        snooze = 2'b01; step(); snooze = 2'b00; step();
        ticks(2);
        stop_alarm = 2'b01; step(); stop_alarm = 2'b00; step();

        // Both channels together, blink on ticks, stop both.
        eq = 2'b11; step();
        eq = 2'b00; step();
        ticks(3);
        stop_alarm = 2'b11; step();
        stop_alarm = 2'b00; step();

        // Stop beats snooze; clear during snooze.
        eq = 2'b01; step(); eq = 2'b00; step();
        stop_alarm = 2'b01; snooze = 2'b01; step();
        stop_alarm = 2'b00; snooze = 2'b00; step();
        eq = 2'b01; step(); eq = 2'b00; step();
        snooze = 2'b01; step(); snooze = 2'b00; tick_step();
        alarm_clear = 1'b1; step(); alarm_clear = 1'b0; step();

        // Rise coincident with a tick: the entering edge does not count it.
        eq = 2'b10; tick = 1'b1; step(); tick = 1'b0; eq = 2'b00; step();
        ticks(5);
        step();

        // Reset mid-ring; eq held high across release needs a fall and rise.
        eq = 2'b01; step(); step();
        async_reset();
        alarm_en = 2'b00; step();
        alarm_en = 2'b11; step(); step(); step();
        eq = 2'b00; step();
        eq = 2'b01; step();
        stop_alarm = 2'b01; step(); stop_alarm = 2'b00; eq = 2'b00; step();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            tick = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 5) == 0) eq[c] = ~eq[c];
                alarm_en[c]   = ($urandom_range(0, 19) != 0);
                stop_alarm[c] = ($urandom_range(0, 29) == 0);
                snooze[c]     = ($urandom_range(0, 9) == 0);
            end
            alarm_clear = ($urandom_range(0, 199) == 0);
            step();
        end
        tick = 1'b0; stop_alarm = '0; snooze = '0; alarm_clear = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
